// File: rtl/mp_writeback_pkg.sv
// rtl/mp_writeback_pkg.sv - shared constants and state encoding for the writeback stage
package mp_writeback_pkg;

  localparam int XLEN_DEF  = 16;
  localparam int RADDR_DEF = 4;
  localparam int NUNIT_DEF = 4;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WR   = 2'd1,
    WB_WLO  = 2'd2,
    WB_WHI  = 2'd3
  } wb_state_e;

  // Only the low beat of a wide write blocks new instructions
  function automatic logic wb_accepts(input wb_state_e s);
    return (s != WB_WLO);
  endfunction

endpackage

// File: rtl/mp_writeback_calc_resmerge.sv
// rtl/mp_writeback_calc_resmerge.sv - OR-merge of the calc-unit result buses
module calc_resmerge #(
  parameter int XLEN  = 16,
  parameter int NUNIT = 4
) (
  input  logic [NUNIT*2*XLEN-1:0] res,
  output logic [2*XLEN-1:0]       merged
);

  // Disabled units drive zero, so a plain OR selects the active one
  always_comb begin
    merged = '0;
    for (int k = 0; k < NUNIT; k++) begin
      merged = merged | res[k*2*XLEN +: 2*XLEN];
    end
  end

endmodule

// File: rtl/mp_writeback.sv
// rtl/mp_writeback.sv - result merge and one/two-beat register-file write port
module mp_writeback
  import mp_writeback_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF,
  parameter int NUNIT = NUNIT_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [NUNIT*2*XLEN-1:0] IN_RES,
  input  logic [RADDR-1:0]        IN_RD,
  input  logic                    IN_WEN,
  input  logic                    IN_WIDE,
  output logic                    RF_WEN,
  output logic [RADDR-1:0]        RF_WADDR,
  output logic [XLEN-1:0]         RF_WDATA,
  output logic                    PEND_VALID,
  output logic [RADDR-1:0]        PEND_ADDR
);

  logic [2*XLEN-1:0] merged;

  wb_state_e         state_q, state_n;
  logic [XLEN-1:0]   lo_q, lo_n;
  logic [XLEN-1:0]   hi_q, hi_n;
  logic [RADDR-1:0]  rd_q, rd_n;
  logic              wen_q, wen_n;
  logic [RADDR-1:0]  rd_inc_n;
  logic              transfer;

  logic              rf_wen_n;
  logic [RADDR-1:0]  rf_waddr_n;
  logic [XLEN-1:0]   rf_wdata_n;
  logic              pend_valid_n;
  logic [RADDR-1:0]  pend_addr_n;
  logic              ready_n;

  calc_resmerge #(
    .XLEN  (XLEN),
    .NUNIT (NUNIT)
  ) u_resmerge (
    .res    (IN_RES),
    .merged (merged)
  );

  assign transfer = IN_VALID & IN_READY;

  // Next state, captured operands and the outputs that the next state will present
  always_comb begin
    state_n = state_q;
    lo_n    = lo_q;
    hi_n    = hi_q;
    rd_n    = rd_q;
    wen_n   = wen_q;

    if (transfer) begin
      lo_n    = merged[XLEN-1:0];
      hi_n    = merged[2*XLEN-1:XLEN];
      rd_n    = IN_RD;
      wen_n   = IN_WEN;
      // A non-writing instruction never needs the second beat, so WIDE is moot
      state_n = (IN_WEN && IN_WIDE) ? WB_WLO : WB_WR;
    end else begin
      case (state_q)
        WB_WLO:  state_n = WB_WHI;
        default: state_n = WB_IDLE;
      endcase
    end

    rd_inc_n = rd_n + RADDR'(1);

    rf_wen_n   = 1'b0;
    rf_waddr_n = '0;
    rf_wdata_n = '0;
    case (state_n)
      WB_WR, WB_WLO: begin
        rf_wen_n   = wen_n && (rd_n != '0);
        rf_waddr_n = rd_n;
        rf_wdata_n = lo_n;
      end
      WB_WHI: begin
        // rd+1 wraps; landing on r0 suppresses the high beat
        rf_wen_n   = wen_n && (rd_inc_n != '0);
        rf_waddr_n = rd_inc_n;
        rf_wdata_n = hi_n;
      end
      default: begin
        rf_wen_n   = 1'b0;
        rf_waddr_n = '0;
        rf_wdata_n = '0;
      end
    endcase

    pend_valid_n = (state_n == WB_WLO) && wen_n;
    pend_addr_n  = pend_valid_n ? rd_inc_n : '0;
    ready_n      = wb_accepts(state_n);
  end

  // State, operand capture and registered write-port outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= WB_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      RF_WEN     <= 1'b0;
      RF_WADDR   <= '0;
      RF_WDATA   <= '0;
      PEND_VALID <= 1'b0;
      PEND_ADDR  <= '0;
      IN_READY   <= 1'b1;
    end else begin
      state_q    <= state_n;
      lo_q       <= lo_n;
      hi_q       <= hi_n;
      rd_q       <= rd_n;
      wen_q      <= wen_n;
      RF_WEN     <= rf_wen_n;
      RF_WADDR   <= rf_waddr_n;
      RF_WDATA   <= rf_wdata_n;
      PEND_VALID <= pend_valid_n;
      PEND_ADDR  <= pend_addr_n;
      IN_READY   <= ready_n;
    end
  end

endmodule

// File: tb/tb_mp_writeback.sv
// tb/tb_mp_writeback.sv - scoreboard bench for the writeback stage
module tb_mp_writeback;

  localparam int XLEN  = 16;
  localparam int RADDR = 4;
  localparam int NUNIT = 4;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic                    IN_VALID;
  logic                    IN_READY;
  logic [NUNIT*2*XLEN-1:0] IN_RES;
  logic [RADDR-1:0]        IN_RD;
  logic                    IN_WEN;
  logic                    IN_WIDE;
  logic                    RF_WEN;
  logic [RADDR-1:0]        RF_WADDR;
  logic [XLEN-1:0]         RF_WDATA;
  logic                    PEND_VALID;
  logic [RADDR-1:0]        PEND_ADDR;

  mp_writeback #(.XLEN(XLEN), .RADDR(RADDR), .NUNIT(NUNIT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_RES     (IN_RES),
    .IN_RD      (IN_RD),
    .IN_WEN     (IN_WEN),
    .IN_WIDE    (IN_WIDE),
    .RF_WEN     (RF_WEN),
    .RF_WADDR   (RF_WADDR),
    .RF_WDATA   (RF_WDATA),
    .PEND_VALID (PEND_VALID),
    .PEND_ADDR  (PEND_ADDR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [RADDR-1:0] addr;
    logic [XLEN-1:0]  data;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic drive(input bit valid, input int unit, input logic [31:0] val,
                       input logic [RADDR-1:0] rd, input bit wen, input bit wide);
    IN_VALID = valid;
    IN_WEN   = wen;
    IN_WIDE  = wide;
    if (valid) begin
      IN_RES = '0;
      IN_RES[unit*32 +: 32] = val;
      IN_RD  = rd;
    end else begin
      IN_RES = 'x;
      IN_RD  = 'x;
    end
  endtask

  // Model: expected register-file writes of one accepted instruction
  task automatic expect_op(input logic [31:0] val, input logic [RADDR-1:0] rd,
                           input bit wen, input bit wide);
    logic [RADDR-1:0] rd1;
    rd1 = rd + 4'd1;
    if (wen && rd != 0) sb.push_back('{addr: rd, data: val[15:0]});
    if (wen && wide && rd1 != 0) sb.push_back('{addr: rd1, data: val[31:16]});
  endtask

  // Advance one cycle, sample at the falling edge, score any write against the queue
  task automatic tick();
    wr_t e;
    @(posedge CLK);
    @(negedge CLK);
    if (RF_WEN === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_write got addr=%0d data=%h, required no write", RF_WADDR, RF_WDATA);
      end else begin
        e = sb.pop_front();
        if ({RF_WADDR, RF_WDATA} !== {e.addr, e.data}) begin
          fails++;
          $display("FAIL sb_write got addr=%0d data=%h, required addr=%0d data=%h",
                   RF_WADDR, RF_WDATA, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(0, 0, 32'h0, 4'd0, 0, 0);
    tick();
    tick();
    tests++;
    if ({RF_WEN, RF_WADDR, RF_WDATA} !== '0) begin
      fails++;
      $display("FAIL reset_rf got wen=%b addr=%0d data=%h, required 0", RF_WEN, RF_WADDR, RF_WDATA);
    end
    tests++;
    if ({PEND_VALID, PEND_ADDR} !== '0) begin
      fails++;
      $display("FAIL reset_pend got %b/%0d, required 0/0", PEND_VALID, PEND_ADDR);
    end
    tests++;
    if (IN_READY !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b, required 1", IN_READY);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_narrow();
    drive(1, 1, 32'h0000_1234, 4'd5, 1, 0);
    expect_op(32'h0000_1234, 4'd5, 1, 0);
    tick();
    tests++;
    if ({RF_WEN, PEND_VALID, IN_READY} !== 3'b101) begin
      fails++;
      $display("FAIL narrow_flags got wen/pend/ready=%b%b%b, required 101", RF_WEN, PEND_VALID, IN_READY);
    end
    drive(0, 0, 32'h0, 4'd0, 0, 0);
    tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL narrow_drain got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_wide_stall();
    drive(1, 3, 32'hDEAD_BEEF, 4'd6, 1, 1);
    expect_op(32'hDEAD_BEEF, 4'd6, 1, 1);
    tick();
    tests++;
    if ({IN_READY, PEND_VALID, PEND_ADDR} !== {1'b0, 1'b1, 4'd7}) begin
      fails++;
      $display("FAIL wide_lo_flags got ready=%b pend=%b paddr=%0d, required 0 1 7", IN_READY, PEND_VALID, PEND_ADDR);
    end
    drive(1, 0, 32'h0000_0055, 4'd9, 1, 0);
    tick();
    tests++;
    if ({RF_WEN, IN_READY, PEND_VALID} !== 3'b110) begin
      fails++;
      $display("FAIL wide_hi_flags got wen/ready/pend=%b%b%b, required 110", RF_WEN, IN_READY, PEND_VALID);
    end
    expect_op(32'h0000_0055, 4'd9, 1, 0);
    tick();
    tests++;
    if ({RF_WEN, RF_WADDR} !== {1'b1, 4'd9}) begin
      fails++;
      $display("FAIL wide_follow got wen=%b addr=%0d, required 1 9", RF_WEN, RF_WADDR);
    end
    drive(0, 0, 32'h0, 4'd0, 0, 0);
    tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL wide_drain got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_wrap_r0();
    drive(1, 0, 32'h0001_0002, 4'd15, 1, 1);
    expect_op(32'h0001_0002, 4'd15, 1, 1);
    tick();
    tests++;
    if ({PEND_VALID, PEND_ADDR} !== {1'b1, 4'd0}) begin
      fails++;
      $display("FAIL wrap_pend got %b/%0d, required 1/0", PEND_VALID, PEND_ADDR);
    end
    drive(0, 0, 32'h0, 4'd0, 0, 0);
    tick();
    tests++;
    if (RF_WEN !== 1'b0) begin
      fails++;
      $display("FAIL wrap_hi_suppress got wen=%b, required 0", RF_WEN);
    end
    tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL wrap_drain got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_suppress();
    drive(1, 2, 32'hFFFF_FFFF, 4'd3, 0, 1);
    expect_op(32'hFFFF_FFFF, 4'd3, 0, 1);
    tick();
    tests++;
    if ({RF_WEN, IN_READY, PEND_VALID} !== 3'b010) begin
      fails++;
      $display("FAIL nowen_first got wen/ready/pend=%b%b%b, required 010", RF_WEN, IN_READY, PEND_VALID);
    end
    tick();
    tests++;
    if ({RF_WEN, IN_READY} !== 2'b01) begin
      fails++;
      $display("FAIL nowen_second got wen/ready=%b%b, required 01", RF_WEN, IN_READY);
    end
    drive(1, 1, 32'h0000_ABCD, 4'd0, 1, 0);
    expect_op(32'h0000_ABCD, 4'd0, 1, 0);
    tick();
    tests++;
    if (RF_WEN !== 1'b0) begin
      fails++;
      $display("FAIL r0_suppress got wen=%b, required 0", RF_WEN);
    end
    drive(0, 0, 32'h0, 4'd0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 32'h1111_2222, 4'd10, 1, 1);
    expect_op(32'h1111_2222, 4'd10, 1, 1);
    void'(sb.pop_back());
    tick();
    RST = 1'b1;
    drive(0, 0, 32'h0, 4'd0, 0, 0);
    tick();
    tests++;
    if ({RF_WEN, PEND_VALID, IN_READY} !== 3'b001) begin
      fails++;
      $display("FAIL rst_mid got wen/pend/ready=%b%b%b, required 001", RF_WEN, PEND_VALID, IN_READY);
    end
    drive(1, 0, 32'h0000_7777, 4'd4, 1, 0);
    tick();
    tests++;
    if (RF_WEN !== 1'b0) begin
      fails++;
      $display("FAIL rst_drop got wen=%b, required 0", RF_WEN);
    end
    RST = 1'b0;
    drive(0, 0, 32'h0, 4'd0, 0, 0);
    tick();
    tick();
    tests++;
    if (RF_WEN !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL rst_no_hi got wen=%b pending=%0d, required 0 0", RF_WEN, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int k = 1; k <= 8; k++) begin
      v = 32'(k) * 32'h11;
      drive(1, k % 4, v, 4'(k), 1, 0);
      expect_op(v, 4'(k), 1, 0);
      tick();
      tests++;
      if ({RF_WEN, IN_READY} !== 2'b11) begin
        fails++;
        $display("FAIL stream_%0d got wen/ready=%b%b, required 11", k, RF_WEN, IN_READY);
      end
    end
    drive(0, 0, 32'h0, 4'd0, 0, 0);
    tick();
    tests++;
    if (RF_WEN !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL stream_drain got wen=%b pending=%0d, required 0 0", RF_WEN, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_narrow();
    test_wide_stall();
    test_wrap_r0();
    test_suppress();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mp_writeback.md
Name: mp_writeback

Overview:
- Result/writeback stage directly downstream of the calc units (arith, logic, bitman, mul).
- Each unit drives a 32-bit result that is forced to zero when its EN is low, so this block OR-merges all unit results and registers the merged word.
- It then drives the register-file write port: one beat for 16-bit results, two beats (rd, then rd+1) for 32-bit results such as a full multiply.
- A valid/ready handshake lets it stall the issue stage during the second beat, and pending-write outputs feed hazard detection.

Parameters:
- XLEN, 16, datapath width; each unit result is 2*XLEN.
- RADDR, 4, register index width.
- NUNIT, 4, number of calc-unit result buses merged.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- IN_VALID  input  1  issue stage presents a completed instruction this cycle.
- IN_READY  output  1  block accepts this cycle; transfer = IN_VALID & IN_READY.
- IN_RES  input  NUNIT*2*XLEN  concatenated unit results; unit k occupies bits [k*2*XLEN +: 2*XLEN]; disabled units are 0.
- IN_RD  input  RADDR  destination register.
- IN_WEN  input  1  instruction writes a register.
- IN_WIDE  input  1  result is 2*XLEN; write low half to rd, high half to rd+1.
- RF_WEN  output  1  register-file write strobe.
- RF_WADDR  output  RADDR  write address.
- RF_WDATA  output  XLEN  write data.
- PEND_VALID  output  1  a high-half write is still queued (next cycle).
- PEND_ADDR  output  RADDR  address of the queued high-half write.

Behaviour:
- Merge: M = OR of all NUNIT unit slices (combinational). Multiple non-zero slices are a protocol error; the OR result is still written, with no detection.
- States: IDLE, WR (narrow write), WLO (wide, low beat), WHI (wide, high beat).
- On transfer, capture M[XLEN-1:0], M[2*XLEN-1:XLEN], IN_RD, IN_WEN, IN_WIDE.
- Next state after transfer:
  - IN_WEN=0 -> WR with writes suppressed.
  - IN_WIDE=1 -> WLO.
  - otherwise -> WR.
- Without a transfer: WR/WHI -> IDLE; WLO -> WHI unconditionally.
- Outputs by state:
  - WR: RF_WEN = wen & (rd != 0), RF_WADDR = rd, RF_WDATA = lo.
  - WLO: same, using the low half.
  - WHI: RF_WEN = wen & (rd+1 != 0), RF_WADDR = rd+1 mod 2^RADDR (wraps), RF_WDATA = hi.
  - IDLE: RF_WEN = 0, RF_WADDR = 0, RF_WDATA = 0.
- Register 0 is hardwired zero: a write to address 0 is suppressed on either beat.
- IN_READY = (state != WLO). Back-to-back transfers are allowed in IDLE, WR and WHI.
- Throughput: one narrow result per cycle; a wide result costs 2 cycles. Latency from transfer to first RF write is 1 cycle.
- PEND_VALID = (state == WLO) & wen; PEND_ADDR = rd+1 mod 2^RADDR, else 0.
- IN_WIDE is ignored when IN_WEN=0 (no WHI beat, no stall).
- Reset: state=IDLE; captured registers cleared; all outputs 0; IN_READY=1 in the cycle after reset. RST asserted in WLO discards the pending high beat. A transfer coincident with RST is dropped.
- IN_RES/IN_RD are sampled only on transfer. X on them while IN_VALID=0 must not propagate to outputs.

Decomposition:
- Shared defines.v gets:
  - WB state encodings WB_IDLE/WB_WR/WB_WLO/WB_WHI (2 bits);
  - XLEN and RADDR defaults alongside the existing TAG_/FLAG_ constants.
- One sub-module, calc_resmerge: parameterised OR-reduction of NUNIT 2*XLEN result buses, combinational.
- The FSM and write-port logic stay in mp_writeback.

Test Plan:
- Narrow write, unit 1 = 32'h0000_1234, others 0, RD=5, WEN=1, WIDE=0 -> next cycle RF_WEN=1, ADDR=5, DATA=16'h1234; PEND_VALID=0; IN_READY stays 1.
- Wide write, unit 3 = 32'hDEAD_BEEF, RD=6, then IN_VALID held with a narrow op -> cycle+1: ADDR=6 DATA=BEEF, IN_READY=0, PEND_VALID=1, PEND_ADDR=7; cycle+2: ADDR=7 DATA=DEAD, narrow op accepted; cycle+3: narrow op written.
- Wrap and r0: wide RD=15 (RADDR=4), result 32'h0001_0002 -> ADDR=15 DATA=2 written; second beat RF_WEN=0 (address wraps to 0).
- Suppression: WEN=0, WIDE=1, any result -> no RF_WEN, no stall, IN_READY=1 throughout. Narrow RD=0 -> RF_WEN=0.
- Reset mid-op: RST in the WLO cycle of a wide write -> next cycle IDLE, RF_WEN=0, PEND_VALID=0, IN_READY=1; no high-half write ever appears.
- Streaming: 8 consecutive narrow ops RD=1..8, DATA=k*0x11 -> 8 consecutive RF writes in order, no bubbles, IN_READY constantly 1.
